sap1_controller_sequencer: RTL and testbench

Control unit for the SAP-1 datapath. It is the initiator that drives the control pins of the program counter, MAR, RAM, IR, accumulator, ALU, B register and output register. A six-state ring counter (T1..T6) runs the fetch-decode-execute cycle and decodes the IR opcode nibble into a 12-bit control word each clock. HLT freezes the machine until reset.

---
 rtl/sap1_controller_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: a six-state one-hot ring counter (T1..T6) plus a halt flag,
// decoding the IR opcode nibble into the 12 datapath control pins every clock.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  ring_t state;
  ring_t state_next;
  logic  halt_flag;
  logic  halt_next;
  ctrl_t ctrl;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= T1;
      halt_flag <= 1'b0;
    end else begin
      state     <= state_next;
      halt_flag <= halt_next;
    end
  end

  // Ring advance; a decoded HLT parks the ring in T5 until clr drops.
  always_comb begin
    state_next = state;
    halt_next  = halt_flag;
    if (!halt_flag) begin
      case (state)
        T1: state_next = T2;
        T2: state_next = T3;
        T3: state_next = T4;
        T4: begin
          state_next = T5;
          if (opcode == OP_HLT) halt_next = 1'b1;
        end
        T5: state_next = T6;
        T6: state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  // Control word decode; reset and halt both force every pin low.
  always_comb begin
    ctrl = '0;
    if (clr && !halt_flag) begin
      case (state)
        T1: begin
          ctrl.ep = 1'b1;
          ctrl.lm = 1'b1;
        end
        T2: ctrl.cp = 1'b1;
        T3: begin
          ctrl.ce = 1'b1;
          ctrl.li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ei = 1'b1;
              ctrl.lm = 1'b1;
            end
            OP_OUT: begin
              ctrl.ea = 1'b1;
              ctrl.lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ce = 1'b1;
              ctrl.la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ce = 1'b1;
              ctrl.lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              ctrl.la = 1'b1;
              ctrl.eu = 1'b1;
            end
            OP_SUB: begin
              ctrl.la = 1'b1;
              ctrl.su = 1'b1;
              ctrl.eu = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign CP      = ctrl.cp;
  assign EP      = ctrl.ep;
  assign LM      = ctrl.lm;
  assign CE      = ctrl.ce;
  assign LI      = ctrl.li;
  assign EI      = ctrl.ei;
  assign LA      = ctrl.la;
  assign EA      = ctrl.ea;
  assign SU      = ctrl.su;
  assign EU      = ctrl.eu;
  assign LB      = ctrl.lb;
  assign LO      = ctrl.lo;
  assign t_state = state;
  assign halted  = halt_flag;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 controller: walks each opcode through its six
// T states and compares the control word, ring state and halt flag per cycle.
module tb_sap1_controller_sequencer;

  logic       clk;
  logic       clr;
  logic [3:0] opcode;
  logic       CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO;
  logic [5:0] t_state;
  logic       halted;
  logic       mon_en;

  int checks;
  int fails;

  // Control word packing {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
  localparam logic [11:0] W_CP = 12'b1000_0000_0000;
  localparam logic [11:0] W_EP = 12'b0100_0000_0000;
  localparam logic [11:0] W_LM = 12'b0010_0000_0000;
  localparam logic [11:0] W_CE = 12'b0001_0000_0000;
  localparam logic [11:0] W_LI = 12'b0000_1000_0000;
  localparam logic [11:0] W_EI = 12'b0000_0100_0000;
  localparam logic [11:0] W_LA = 12'b0000_0010_0000;
  localparam logic [11:0] W_EA = 12'b0000_0001_0000;
  localparam logic [11:0] W_SU = 12'b0000_0000_1000;
  localparam logic [11:0] W_EU = 12'b0000_0000_0100;
  localparam logic [11:0] W_LB = 12'b0000_0000_0010;
  localparam logic [11:0] W_LO = 12'b0000_0000_0001;

  localparam logic [11:0] W_FETCH1 = W_EP | W_LM;
  localparam logic [11:0] W_FETCH2 = W_CP;
  localparam logic [11:0] W_FETCH3 = W_CE | W_LI;

  logic [11:0] ctrl_obs;
  assign ctrl_obs = {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};

  sap1_controller_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .opcode  (opcode),
    .CP      (CP),
    .EP      (EP),
    .LM      (LM),
    .CE      (CE),
    .LI      (LI),
    .EI      (EI),
    .LA      (LA),
    .EA      (EA),
    .SU      (SU),
    .EU      (EU),
    .LB      (LB),
    .LO      (LO),
    .t_state (t_state),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus exclusivity and SU-implies-EU checked on every falling edge once out of power-up.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (($countones({EP, CE, EI, EA, EU}) > 1) || (SU && !EU)) begin
        fails++;
        $display("FAIL bus_excl t=%0t drivers EP,CE,EI,EA,EU=%b SU=%b required at most one driver and SU only with EU",
                 $time, {EP, CE, EI, EA, EU}, SU);
      end
    end
  end

  task automatic test_reset();
    clr = 1'b0;
    opcode = 4'b1010;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (ctrl_obs !== 12'h000) begin
        fails++;
        $display("FAIL reset_ctrl got %b required %b", ctrl_obs, 12'h000);
      end
    end
    mon_en = 1'b1;
    checks++;
    if (t_state !== 6'b000001) begin
      fails++;
      $display("FAIL reset_tstate got %b required %b", t_state, 6'b000001);
    end
    checks++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_halted got %b required 0", halted);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (ctrl_obs !== W_FETCH1) begin
      fails++;
      $display("FAIL reset_release_ctrl got %b required %b", ctrl_obs, W_FETCH1);
    end
  endtask

  task automatic test_lda();
    logic [11:0] exp_w [6];
    exp_w = '{W_FETCH1, W_FETCH2, W_FETCH3, W_EI | W_LM, W_CE | W_LA, 12'h000};
    opcode = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_w[i]) begin
        fails++;
        $display("FAIL lda_T%0d got state %b ctrl %b required state %b ctrl %b",
                 i + 1, t_state, ctrl_obs, 6'b000001 << i, exp_w[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (t_state !== 6'b000001) begin
      fails++;
      $display("FAIL lda_wrap got %b required %b", t_state, 6'b000001);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_add [6];
    logic [11:0] exp_sub [6];
    exp_add = '{W_FETCH1, W_FETCH2, W_FETCH3, W_EI | W_LM, W_CE | W_LB, W_LA | W_EU};
    exp_sub = '{W_FETCH1, W_FETCH2, W_FETCH3, W_EI | W_LM, W_CE | W_LB, W_LA | W_SU | W_EU};
    opcode = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_add[i]) begin
        fails++;
        $display("FAIL add_T%0d got state %b ctrl %b required state %b ctrl %b",
                 i + 1, t_state, ctrl_obs, 6'b000001 << i, exp_add[i]);
      end
      @(posedge clk); #1;
    end
    opcode = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_sub[i]) begin
        fails++;
        $display("FAIL sub_T%0d got state %b ctrl %b required state %b ctrl %b",
                 i + 1, t_state, ctrl_obs, 6'b000001 << i, exp_sub[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_out_nop();
    logic [11:0] exp_out [6];
    logic [11:0] exp_nop [6];
    exp_out = '{W_FETCH1, W_FETCH2, W_FETCH3, W_EA | W_LO, 12'h000, 12'h000};
    exp_nop = '{W_FETCH1, W_FETCH2, W_FETCH3, 12'h000, 12'h000, 12'h000};
    opcode = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_out[i]) begin
        fails++;
        $display("FAIL out_T%0d got state %b ctrl %b required state %b ctrl %b",
                 i + 1, t_state, ctrl_obs, 6'b000001 << i, exp_out[i]);
      end
      @(posedge clk); #1;
    end
    opcode = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_nop[i]) begin
        fails++;
        $display("FAIL nop_T%0d got state %b ctrl %b required state %b ctrl %b",
                 i + 1, t_state, ctrl_obs, 6'b000001 << i, exp_nop[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0) begin
      fails++;
      $display("FAIL nop_wrap got state %b halted %b required state %b halted 0",
               t_state, halted, 6'b000001);
    end
  endtask

  task automatic test_hlt();
    logic [11:0] exp_w [4];
    exp_w = '{W_FETCH1, W_FETCH2, W_FETCH3, 12'h000};
    opcode = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (t_state !== (6'b000001 << i) || ctrl_obs !== exp_w[i] || halted !== 1'b0) begin
        fails++;
        $display("FAIL hlt_T%0d got state %b ctrl %b halted %b required state %b ctrl %b halted 0",
                 i + 1, t_state, ctrl_obs, halted, 6'b000001 << i, exp_w[i]);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      opcode = (i % 2 == 0) ? 4'b0001 : 4'b1111;
      #1;
      checks++;
      if (halted !== 1'b1 || t_state !== 6'b010000 || ctrl_obs !== 12'h000) begin
        fails++;
        $display("FAIL hlt_hold%0d got halted %b state %b ctrl %b required halted 1 state %b ctrl %b",
                 i, halted, t_state, ctrl_obs, 6'b010000, 12'h000);
      end
      @(posedge clk); #1;
    end
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    opcode = 4'b0000;
    #1;
    checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0 || ctrl_obs !== W_FETCH1) begin
      fails++;
      $display("FAIL hlt_exit got state %b halted %b ctrl %b required state %b halted 0 ctrl %b",
               t_state, halted, ctrl_obs, 6'b000001, W_FETCH1);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 4'b0001;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (t_state !== 6'b010000 || ctrl_obs !== (W_CE | W_LB)) begin
      fails++;
      $display("FAIL mid_T5 got state %b ctrl %b required state %b ctrl %b",
               t_state, ctrl_obs, 6'b010000, W_CE | W_LB);
    end
    clr = 1'b0;
    #1;
    checks++;
    if (ctrl_obs !== 12'h000) begin
      fails++;
      $display("FAIL mid_clr_ctrl got %b required %b", ctrl_obs, 12'h000);
    end
    @(posedge clk); #1;
    checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0 || ctrl_obs !== 12'h000) begin
      fails++;
      $display("FAIL mid_reset got state %b halted %b ctrl %b required state %b halted 0 ctrl %b",
               t_state, halted, ctrl_obs, 6'b000001, 12'h000);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (ctrl_obs !== W_FETCH1) begin
      fails++;
      $display("FAIL mid_release got %b required %b", ctrl_obs, W_FETCH1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    mon_en = 1'b0;
    clr    = 1'b0;
    opcode = 4'b0000;
    test_reset();
    test_lda();
    test_back_to_back();
    test_out_nop();
    test_hlt();
    test_reset_mid();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
